// File: rtl/acc_seq_param.sv
// acc_seq_param: sequences NUM_LAYERS compute layers over valid/ready handshakes.
// It muxes the shared weight-RAM address to the active layer and captures the
// final-layer scores. A sequential argmax over those scores picks the winning class.
// A per-layer watchdog and an abort input can end a run early.
module acc_seq_param #(
    parameter int NUM_LAYERS  = 3,
    parameter int WADDR_W     = 9,
    parameter int NUM_CLASSES = 10,
    parameter int RES_W       = 8,
    parameter int TIMEOUT_W   = 16,
    parameter int CLS_W       = $clog2(NUM_CLASSES)
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start_valid_i,
    output logic                           start_ready_o,
    input  logic                           abort_i,
    output logic [NUM_LAYERS-1:0]          layer_valid_o,
    input  logic [NUM_LAYERS-1:0]          layer_ready_i,
    input  logic [NUM_LAYERS*WADDR_W-1:0]  layer_waddr_i,
    output logic [WADDR_W-1:0]             wt_addr_o,
    input  logic [NUM_CLASSES*RES_W-1:0]   res_i,
    output logic [NUM_CLASSES*RES_W-1:0]   res_o,
    output logic [CLS_W-1:0]               class_o,
    input  logic [TIMEOUT_W-1:0]           timeout_cfg_i,
    output logic                           err_o,
    output logic                           irq_o,
    output logic [31:0]                    cycles_o
);

    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);
    localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(NUM_CLASSES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_ARGMAX = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;

    logic [2:0]                     state_reg, state_next;
    logic [IDX_W-1:0]               idx_reg, idx_next;
    logic [CLS_W-1:0]               sidx_reg, sidx_next;
    logic [CLS_W-1:0]               best_reg, best_next;
    logic [CLS_W-1:0]               class_reg, class_next;
    logic [TIMEOUT_W-1:0]           wd_reg, wd_next;
    logic [31:0]                    cycles_reg, cycles_next;
    logic [NUM_CLASSES*RES_W-1:0]   res_reg, res_next;
    logic                           err_reg, err_next;
    logic                           irq_reg, irq_next;

    logic [WADDR_W-1:0]             waddr_arr [NUM_LAYERS];
    logic signed [RES_W-1:0]        score_arr [NUM_CLASSES];
    logic signed [RES_W-1:0]        cur_score, best_score;
    logic                           ready_cur;
    logic [TIMEOUT_W:0]             wd_inc;
    logic                           timeout_hit;
    logic [CLS_W-1:0]               best_upd;

    // Per-layer slices and the one-hot layer enable decoded from state and idx
    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
            assign waddr_arr[gi]     = layer_waddr_i[gi*WADDR_W +: WADDR_W];
            assign layer_valid_o[gi] = (state_reg == S_RUN) && (idx_reg == IDX_W'(gi));
        end
        for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_score
            assign score_arr[gi] = res_reg[gi*RES_W +: RES_W];
        end
    endgenerate

    // Select the active layer's weight address and ready bit
    always_comb begin
        wt_addr_o = '0;
        ready_cur = 1'b0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (idx_reg == IDX_W'(k)) begin
                wt_addr_o = waddr_arr[k];
                ready_cur = layer_ready_i[k];
            end
        end
    end

    // Fetch the two captured scores that the argmax compares this cycle
    always_comb begin
        cur_score  = '0;
        best_score = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (sidx_reg == CLS_W'(k)) cur_score = score_arr[k];
            if (best_reg == CLS_W'(k)) best_score = score_arr[k];
        end
    end

    // A strictly greater score replaces the running best, so ties keep the lower index
    assign best_upd    = (cur_score > best_score) ? sidx_reg : best_reg;
    assign wd_inc      = {1'b0, wd_reg} + (TIMEOUT_W+1)'(1);
    assign timeout_hit = (timeout_cfg_i != '0) && (wd_inc >= {1'b0, timeout_cfg_i});

    // Next-state logic: the priority order is abort, then timeout, then layer ready
    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        sidx_next   = sidx_reg;
        best_next   = best_reg;
        class_next  = class_reg;
        wd_next     = wd_reg;
        cycles_next = cycles_reg;
        res_next    = res_reg;
        err_next    = err_reg;
        irq_next    = 1'b0;

        if ((state_reg == S_RUN || state_reg == S_ARGMAX) && cycles_reg != 32'hFFFF_FFFF)
            cycles_next = cycles_reg + 32'd1;

        case (state_reg)
            S_IDLE: begin
                if (start_valid_i) begin
                    state_next  = S_RUN;
                    idx_next    = '0;
                    wd_next     = '0;
                    cycles_next = '0;
                    err_next    = 1'b0;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_next = S_IDLE;
                    idx_next   = '0;
                    wd_next    = '0;
                end else if (timeout_hit) begin
                    state_next = S_ERR;
                    idx_next   = '0;
                    wd_next    = '0;
                    err_next   = 1'b1;
                    irq_next   = 1'b1;
                end else if (ready_cur) begin
                    wd_next = '0;
                    if (idx_reg == LAST_IDX) begin
                        state_next = S_ARGMAX;
                        idx_next   = '0;
                        res_next   = res_i;
                        sidx_next  = CLS_W'(1);
                        best_next  = '0;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end else if (timeout_cfg_i != '0) begin
                    wd_next = wd_inc[TIMEOUT_W-1:0];
                end
            end
            S_ARGMAX: begin
                if (abort_i) begin
                    state_next = S_IDLE;
                    sidx_next  = '0;
                end else begin
                    best_next = best_upd;
                    if (sidx_reg == LAST_CLS) begin
                        class_next = best_upd;
                        state_next = S_DONE;
                        sidx_next  = '0;
                        irq_next   = 1'b1;
                    end else begin
                        sidx_next = sidx_reg + CLS_W'(1);
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (!start_valid_i) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State and status registers; reset returns everything to zero at once
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= S_IDLE;
            idx_reg    <= '0;
            sidx_reg   <= '0;
            best_reg   <= '0;
            class_reg  <= '0;
            wd_reg     <= '0;
            cycles_reg <= '0;
            res_reg    <= '0;
            err_reg    <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            sidx_reg   <= sidx_next;
            best_reg   <= best_next;
            class_reg  <= class_next;
            wd_reg     <= wd_next;
            cycles_reg <= cycles_next;
            res_reg    <= res_next;
            err_reg    <= err_next;
            irq_reg    <= irq_next;
        end
    end

    assign start_ready_o = (state_reg == S_DONE) || (state_reg == S_ERR);
    assign res_o         = res_reg;
    assign class_o       = class_reg;
    assign err_o         = err_reg;
    assign irq_o         = irq_reg;
    assign cycles_o      = cycles_reg;

endmodule

// File: tb/tb_acc_seq_param.sv
// Directed testbench for acc_seq_param: default instance plus two parameter variants.
module tb_acc_seq_param;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Default instance (3 layers, 10 classes)
    logic        start = 1'b0, abort = 1'b0;
    logic [2:0]  lready = '0, lvalid;
    logic [26:0] lwaddr = {9'h1C3, 9'h0B2, 9'h0A1};
    logic [8:0]  wt;
    logic [79:0] res_in = '0, res_out;
    logic [3:0]  cls;
    logic [15:0] tcfg = '0;
    logic        sready, err, irq;
    logic [31:0] cyc;
    logic [8:0]  exp_wa [3] = '{9'h0A1, 9'h0B2, 9'h1C3};

    acc_seq_param dut (
        .clk(clk), .rstn(rstn), .start_valid_i(start), .start_ready_o(sready),
        .abort_i(abort), .layer_valid_o(lvalid), .layer_ready_i(lready),
        .layer_waddr_i(lwaddr), .wt_addr_o(wt), .res_i(res_in), .res_o(res_out),
        .class_o(cls), .timeout_cfg_i(tcfg), .err_o(err), .irq_o(irq), .cycles_o(cyc)
    );

    // Small instance: 1 layer, 2 classes
    logic        s_start = 1'b0, s_abort = 1'b0;
    logic [0:0]  s_ready = '0, s_valid;
    logic [8:0]  s_waddr = 9'h1A5, s_wt;
    logic [15:0] s_res_in = 16'h01FE, s_res_out;
    logic [0:0]  s_cls;
    logic [15:0] s_tcfg = '0;
    logic        s_sready, s_err, s_irq;
    logic [31:0] s_cyc;

    acc_seq_param #(.NUM_LAYERS(1), .NUM_CLASSES(2)) dut_s (
        .clk(clk), .rstn(rstn), .start_valid_i(s_start), .start_ready_o(s_sready),
        .abort_i(s_abort), .layer_valid_o(s_valid), .layer_ready_i(s_ready),
        .layer_waddr_i(s_waddr), .wt_addr_o(s_wt), .res_i(s_res_in), .res_o(s_res_out),
        .class_o(s_cls), .timeout_cfg_i(s_tcfg), .err_o(s_err), .irq_o(s_irq), .cycles_o(s_cyc)
    );

    // Large instance: 6 layers, 12-bit weight address
    logic        l_start = 1'b0, l_abort = 1'b0;
    logic [5:0]  l_ready = '0, l_valid;
    logic [71:0] l_waddr = '0;
    logic [11:0] l_wt;
    logic [79:0] l_res_in = '0, l_res_out;
    logic [3:0]  l_cls;
    logic [15:0] l_tcfg = '0;
    logic        l_sready, l_err, l_irq;
    logic [31:0] l_cyc;

    acc_seq_param #(.NUM_LAYERS(6), .WADDR_W(12)) dut_l (
        .clk(clk), .rstn(rstn), .start_valid_i(l_start), .start_ready_o(l_sready),
        .abort_i(l_abort), .layer_valid_o(l_valid), .layer_ready_i(l_ready),
        .layer_waddr_i(l_waddr), .wt_addr_o(l_wt), .res_i(l_res_in), .res_o(l_res_out),
        .class_o(l_cls), .timeout_cfg_i(l_tcfg), .err_o(l_err), .irq_o(l_irq), .cycles_o(l_cyc)
    );

    // Count irq pulses of the default instance
    int irq_cnt = 0;
    always @(negedge clk) if (irq === 1'b1) irq_cnt <= irq_cnt + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full run on the default instance, each layer ready dly cycles after its valid
    task automatic drive_run(input int dly, output int n);
        start = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            repeat (dly - 1) tick();
            lready = 3'(1 << k);
            tick();
            lready = '0;
        end
        n = 0;
        while (sready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if ({lvalid, sready, err, irq} !== 6'd0) begin n_fail++; $display("FAIL reset_ctrl: got %b, want 000000", {lvalid, sready, err, irq}); end
        n_checks++; if (cyc !== 32'd0 || cls !== 4'd0 || res_out !== 80'd0) begin n_fail++; $display("FAIL reset_data: got cyc=%0d cls=%0d res=%h, want zeros", cyc, cls, res_out); end
        n_checks++; if ({s_valid, s_sready, s_err, s_irq, l_valid, l_sready, l_err, l_irq} !== 12'd0) begin n_fail++; $display("FAIL reset_variants: got %b, want 0", {s_valid, s_sready, s_err, s_irq, l_valid, l_sready, l_err, l_irq}); end
        @(negedge clk) rstn = 1'b1;
        tick();
        $display("reset: outputs checked");
    endtask

    task automatic test_nominal;
        int v[10] = '{-3, 7, 2, 7, 1, 1, 1, 1, 1, 1};
        int n = 0;
        int irq0 = irq_cnt;
        for (int j = 0; j < 10; j++) res_in[j*8 +: 8] = 8'(v[j]);
        tcfg = '0;
        start = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (lvalid !== 3'(1 << k)) begin n_fail++; $display("FAIL nom_valid%0d: got %b, want %b", k, lvalid, 3'(1 << k)); end
            n_checks++; if (wt !== exp_wa[k]) begin n_fail++; $display("FAIL nom_waddr%0d: got %h, want %h", k, wt, exp_wa[k]); end
            repeat (4) tick();
            lready = 3'(1 << k);
            tick();
            lready = '0;
        end
        n_checks++; if (lvalid !== 3'b000 || res_out !== res_in) begin n_fail++; $display("FAIL nom_capture: got valid=%b res=%h, want 000 / %h", lvalid, res_out, res_in); end
        while (sready !== 1'b1 && n < 40) begin tick(); n++; end
        n_checks++; if (n !== 9) begin n_fail++; $display("FAIL nom_latency: got %0d, want 9", n); end
        n_checks++; if (irq !== 1'b1 || cls !== 4'd1) begin n_fail++; $display("FAIL nom_done: got irq=%b cls=%0d, want 1 / 1", irq, cls); end
        n_checks++; if (cyc !== 32'd24 || err !== 1'b0) begin n_fail++; $display("FAIL nom_cycles: got cyc=%0d err=%b, want 24 / 0", cyc, err); end
        tick();
        n_checks++; if (irq !== 1'b0 || sready !== 1'b1) begin n_fail++; $display("FAIL nom_irq_width: got irq=%b rdy=%b, want 0 / 1", irq, sready); end
        n_checks++; if (irq_cnt - irq0 !== 1) begin n_fail++; $display("FAIL nom_irq_count: got %0d, want 1", irq_cnt - irq0); end
        start = 1'b0;
        tick();
        n_checks++; if (sready !== 1'b0) begin n_fail++; $display("FAIL nom_idle: got rdy=%b, want 0", sready); end
        $display("nominal run: class=%0d cycles=%0d latency=%0d", cls, cyc, n);
    endtask

    task automatic test_signed;
        int n;
        for (int j = 0; j < 10; j++) res_in[j*8 +: 8] = (j == 9) ? 8'hFF : 8'h80;
        drive_run(1, n);
        n_checks++; if (cls !== 4'd9 || n !== 9) begin n_fail++; $display("FAIL signed_max: got cls=%0d lat=%0d, want 9 / 9", cls, n); end
        start = 1'b0;
        tick();
        for (int j = 0; j < 10; j++) res_in[j*8 +: 8] = 8'h05;
        drive_run(2, n);
        n_checks++; if (cls !== 4'd0) begin n_fail++; $display("FAIL signed_equal: got cls=%0d, want 0", cls); end
        start = 1'b0;
        tick();
        $display("signed compare: last class=%0d", cls);
    endtask

    task automatic test_watchdog;
        int n = 0;
        logic [79:0] old_res;
        for (int j = 0; j < 10; j++) old_res[j*8 +: 8] = 8'h05;
        for (int j = 0; j < 10; j++) res_in[j*8 +: 8] = (j == 4) ? 8'd50 : 8'd0;
        tcfg = 16'd8;
        start = 1'b1;
        tick();
        repeat (2) tick();
        lready = 3'b001;
        tick();
        lready = '0;
        n_checks++; if (lvalid !== 3'b010) begin n_fail++; $display("FAIL wd_layer1: got %b, want 010", lvalid); end
        while (err !== 1'b1 && n < 20) begin tick(); n++; end
        n_checks++; if (n !== 8) begin n_fail++; $display("FAIL wd_latency: got %0d, want 8", n); end
        n_checks++; if ({err, irq, sready, lvalid} !== 6'b111000) begin n_fail++; $display("FAIL wd_err_state: got %b, want 111000", {err, irq, sready, lvalid}); end
        n_checks++; if (res_out !== old_res) begin n_fail++; $display("FAIL wd_res_hold: got %h, want %h", res_out, old_res); end
        start = 1'b0;
        tick();
        n_checks++; if (sready !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL wd_idle: got rdy=%b err=%b, want 0 / 1", sready, err); end
        tcfg = '0;
        start = 1'b1;
        tick();
        n_checks++; if (err !== 1'b0 || lvalid !== 3'b001) begin n_fail++; $display("FAIL wd_restart: got err=%b valid=%b, want 0 / 001", err, lvalid); end
        for (int k = 0; k < 3; k++) begin
            lready = 3'(1 << k);
            tick();
        end
        lready = '0;
        n = 0;
        while (sready !== 1'b1 && n < 40) begin tick(); n++; end
        n_checks++; if (cls !== 4'd4 || err !== 1'b0) begin n_fail++; $display("FAIL wd_rerun: got cls=%0d err=%b, want 4 / 0", cls, err); end
        start = 1'b0;
        tick();
        // Ready arriving on the same edge the limit is reached loses to the timeout
        tcfg = 16'd4;
        start = 1'b1;
        tick();
        repeat (3) tick();
        lready = 3'b001;
        tick();
        lready = '0;
        n_checks++; if ({err, sready, lvalid} !== 5'b11000) begin n_fail++; $display("FAIL wd_tie: got %b, want 11000", {err, sready, lvalid}); end
        start = 1'b0;
        tcfg = '0;
        tick();
        $display("watchdog: timeout after %0d cycles, tie case err=%b", 8, err);
    endtask

    task automatic test_abort;
        int irq0 = irq_cnt;
        start = 1'b1;
        tick();
        lready = 3'b001; tick();
        lready = 3'b010; tick();
        lready = '0;
        n_checks++; if (lvalid !== 3'b100) begin n_fail++; $display("FAIL abort_layer2: got %b, want 100", lvalid); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++; if (lvalid !== 3'b000 || sready !== 1'b0) begin n_fail++; $display("FAIL abort_run: got valid=%b rdy=%b, want 000 / 0", lvalid, sready); end
        tick();
        n_checks++; if (lvalid !== 3'b001) begin n_fail++; $display("FAIL abort_idle_restart: got %b, want 001", lvalid); end
        abort = 1'b1;
        start = 1'b0;
        tick();
        abort = 1'b0;
        for (int j = 0; j < 10; j++) res_in[j*8 +: 8] = (j == 5) ? 8'd100 : 8'd0;
        start = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            lready = 3'(1 << k);
            tick();
        end
        lready = '0;
        repeat (3) tick();
        abort = 1'b1;
        start = 1'b0;
        tick();
        abort = 1'b0;
        repeat (12) tick();
        n_checks++; if (sready !== 1'b0 || cls !== 4'd4) begin n_fail++; $display("FAIL abort_argmax: got rdy=%b cls=%0d, want 0 / 4", sready, cls); end
        n_checks++; if (irq_cnt - irq0 !== 0 || err !== 1'b0) begin n_fail++; $display("FAIL abort_no_irq: got irqs=%0d err=%b, want 0 / 0", irq_cnt - irq0, err); end
        $display("abort: class held at %0d", cls);
    endtask

    task automatic test_params;
        int n = 0;
        s_start = 1'b1;
        tick();
        n_checks++; if (s_valid !== 1'b1 || s_wt !== 9'h1A5) begin n_fail++; $display("FAIL small_valid: got v=%b a=%h, want 1 / 1a5", s_valid, s_wt); end
        s_ready = 1'b1;
        tick();
        s_ready = 1'b0;
        while (s_sready !== 1'b1 && n < 10) begin tick(); n++; end
        n_checks++; if (n !== 1 || s_cls !== 1'b1) begin n_fail++; $display("FAIL small_done: got lat=%0d cls=%0d, want 1 / 1", n, s_cls); end
        n_checks++; if (s_res_out !== 16'h01FE || s_cyc !== 32'd2 || s_irq !== 1'b1 || s_err !== 1'b0) begin n_fail++; $display("FAIL small_status: got res=%h cyc=%0d irq=%b err=%b, want 01fe / 2 / 1 / 0", s_res_out, s_cyc, s_irq, s_err); end
        s_start = 1'b0;
        for (int k = 0; k < 6; k++) l_waddr[k*12 +: 12] = 12'h0A0 + 12'(k) * 12'h111;
        l_res_in[2*8 +: 8] = 8'h30;
        l_res_in[7*8 +: 8] = 8'h30;
        l_start = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (l_valid !== 6'(1 << k) || l_wt !== 12'h0A0 + 12'(k) * 12'h111) begin n_fail++; $display("FAIL large_layer%0d: got v=%b a=%h, want %b / %h", k, l_valid, l_wt, 6'(1 << k), 12'h0A0 + 12'(k) * 12'h111); end
            l_ready = 6'(1 << k);
            tick();
            l_ready = '0;
        end
        n = 0;
        while (l_sready !== 1'b1 && n < 40) begin tick(); n++; end
        n_checks++; if (n !== 9 || l_cls !== 4'd2) begin n_fail++; $display("FAIL large_done: got lat=%0d cls=%0d, want 9 / 2", n, l_cls); end
        n_checks++; if (l_cyc !== 32'd15 || l_res_out !== l_res_in || l_irq !== 1'b1 || l_err !== 1'b0) begin n_fail++; $display("FAIL large_status: got cyc=%0d irq=%b err=%b, want 15 / 1 / 0", l_cyc, l_irq, l_err); end
        l_start = 1'b0;
        tick();
        $display("param sweep: small class=%0d large class=%0d", s_cls, l_cls);
    endtask

    task automatic test_async_reset;
        int v[10] = '{-3, 7, 2, 7, 1, 1, 1, 1, 1, 1};
        int n;
        for (int j = 0; j < 10; j++) res_in[j*8 +: 8] = 8'(v[j]);
        start = 1'b1;
        tick();
        lready = 3'b001; tick();
        lready = '0; tick();
        #2 rstn = 1'b0;
        #1;
        n_checks++; if ({lvalid, sready, err, irq} !== 6'd0 || cyc !== 32'd0) begin n_fail++; $display("FAIL arst_ctrl: got %b cyc=%0d, want 0 / 0", {lvalid, sready, err, irq}, cyc); end
        n_checks++; if (res_out !== 80'd0 || cls !== 4'd0) begin n_fail++; $display("FAIL arst_data: got res=%h cls=%0d, want 0 / 0", res_out, cls); end
        start = 1'b0;
        @(negedge clk) rstn = 1'b1;
        tick();
        drive_run(5, n);
        n_checks++; if (n !== 9 || cls !== 4'd1 || cyc !== 32'd24) begin n_fail++; $display("FAIL arst_rerun: got lat=%0d cls=%0d cyc=%0d, want 9 / 1 / 24", n, cls, cyc); end
        start = 1'b0;
        tick();
        $display("async reset: rerun class=%0d cycles=%0d", cls, cyc);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_signed();
        test_watchdog();
        test_abort();
        test_params();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_seq_param.md
# acc_seq_param

Parametrised successor to the fixed three-stage accelerator top controller. It sequences NUM_LAYERS compute layers through per-layer valid/ready handshakes and muxes the shared weight-RAM address to the active layer. It then captures the final-layer class scores, finds the winning class with a sequential argmax, and reports done, error and cycle-count status to the SoC bus slave. Per-layer watchdog timeout and abort are new in this generation.

## Interface
- NUM_LAYERS, 3: number of sequenced layers (≥1)
- WADDR_W, 9: weight-RAM address width
- NUM_CLASSES, 10: number of class scores (≥2)
- RES_W, 8: score width, signed two's complement
- TIMEOUT_W, 16: watchdog counter width
- CLS_W, $clog2(NUM_CLASSES): class index width (derived)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start_valid_i  in  1  level request; held high until done is seen
- start_ready_o  out  1  high in DONE or ERR
- abort_i  in  1  cancel the current run
- layer_valid_o  out  NUM_LAYERS  one-hot; bit k = layer k enabled
- layer_ready_i  in  NUM_LAYERS  bit k = layer k finished
- layer_waddr_i  in  NUM_LAYERS*WADDR_W  per-layer weight address; slice k = layer k
- wt_addr_o  out  WADDR_W  shared weight-RAM address
- res_i  in  NUM_CLASSES*RES_W  final-layer scores; slice j = class j
- res_o  out  NUM_CLASSES*RES_W  captured scores
- class_o  out  CLS_W  argmax result
- timeout_cfg_i  in  TIMEOUT_W  per-layer cycle limit; 0 disables the watchdog
- err_o  out  1  timeout flag
- irq_o  out  1  one-cycle pulse on entering DONE or ERR
- cycles_o  out  32  run-length counter

## Operation
- States: IDLE, RUN, ARGMAX, DONE, ERR. Layer index idx and scan index sidx are registers.
- IDLE:
  - start_valid_i=1 → RUN with idx=0.
  - On this transition: cycles_o, err_o and the watchdog are cleared.
- RUN:
  - layer_valid_o = 1<<idx (registered, Moore).
  - Only layer_ready_i[idx] is sampled; all other bits are ignored.
  - On ready with idx<NUM_LAYERS-1: idx+1 and the watchdog clears.
  - On ready with idx=NUM_LAYERS-1: res_o ← res_i, state → ARGMAX, sidx=1, best=0.
- wt_addr_o = layer_waddr_i slice idx in every state. idx is 0 outside RUN.
- ARGMAX:
  - One comparison per cycle: if signed res_o[sidx] > res_o[best], then best ← sidx.
  - Ties keep the lower index.
  - After sidx=NUM_CLASSES-1 is compared: class_o ← final best, state → DONE.
- DONE: start_ready_o=1. Stays until start_valid_i=0, then → IDLE.
- Watchdog:
  - In RUN with timeout_cfg_i≠0, the counter increments every cycle the active layer is not ready.
  - Counter reaching timeout_cfg_i → ERR, err_o=1, layer_valid_o=0.
- ERR: start_ready_o=1. → IDLE when start_valid_i=0. err_o holds until the next start.
- abort_i:
  - In RUN or ARGMAX: → IDLE next cycle and layer_valid_o=0.
  - res_o, class_o and err_o are not updated. No irq.
  - Ignored in IDLE, DONE and ERR.
- cycles_o:
  - Counts every cycle spent in RUN and ARGMAX; saturates at 2^32-1.
  - Holds its value outside RUN and ARGMAX.
- Priority inside one cycle: abort_i > timeout > layer ready.
- start_valid_i dropping during RUN/ARGMAX is ignored; the run completes.

## Timing
- Reset values: all outputs 0. State IDLE, idx=0, sidx=0.
- start_valid_i sampled high at edge t → layer_valid_o[0]=1 from t+1.
- layer_ready_i[k] at edge t → layer_valid_o[k+1] from t+1; no idle gap.
- Last-layer ready at edge t → res_o valid from t+1.
  - ARGMAX occupies NUM_CLASSES-1 cycles.
  - DONE, class_o, start_ready_o and irq_o all appear at t+NUM_CLASSES.
- irq_o is exactly 1 cycle wide, coincident with the first DONE/ERR cycle.
- Timeout: with limit L, ERR is entered L cycles after the layer's first valid cycle, provided no ready arrives.
- Asynchronous reset mid-run returns everything to reset values immediately. The watchdog and counters clear.
- Ready on the same edge the watchdog reaches L: timeout wins, state → ERR.

## Test plan
- Nominal run, default parameters, timeout_cfg_i=0:
  - Stimulus: each layer is ready 5 cycles after its valid; res_i = {-3,7,2,7,...}.
  - Required: layer_valid_o sequence 001→010→100; class_o=1 (tie with index 3 keeps lower).
  - Required: DONE 10 cycles after the last ready; one irq pulse; cycles_o=24.
- Signed compare:
  - Stimulus: all scores -128 except class 9 = -1.
  - Required: class_o=9. With all scores equal: class_o=0.
- Watchdog:
  - Stimulus: timeout_cfg_i=8; layer 1 never ready.
  - Required: ERR 8 cycles after layer_valid_o[1] rises; err_o=1, irq pulse, layer_valid_o=0, res_o unchanged.
  - Required: drop start_valid_i → IDLE; next start clears err_o.
- Abort:
  - Stimulus: abort_i during layer 2, and separately during ARGMAX.
  - Required: IDLE next cycle; no irq; class_o keeps its previous value.
- Parameter sweep:
  - Stimulus: NUM_LAYERS=1, NUM_CLASSES=2, and NUM_LAYERS=6, WADDR_W=12.
  - Required: wt_addr_o tracks the active slice in both; DONE latency = NUM_CLASSES cycles.
- Asynchronous reset asserted mid-RUN:
  - Required: all outputs 0 immediately.
  - Required: a fresh start completes normally, with cycles_o counting from 0.
